// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n holds the pattern for nibble value n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

endpackage

// File: rtl/display_scan_controller_hex_to_7seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed N-digit 7-segment driver: prescaled scan, dead time between
// digits, per-digit blanking and a global enable. All outputs registered.
module display_scan_controller
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic [4*NUM_DIGITS-1:0]       i_digit_data,
    input  logic [NUM_DIGITS-1:0]         i_digit_enable,
    input  logic [NUM_DIGITS-1:0]         i_dot_in,
    output logic [NUM_DIGITS-1:0]         o_digit_sel,
    output logic [6:0]                    o_segments,
    output logic                          o_dot,
    output logic [$clog2(NUM_DIGITS)-1:0] o_scan_idx
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DOT_OFF = (SEG_ACTIVE_LOW != 0);

    scan_state_e r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [3:0]    r_sh_nib;
    logic          r_sh_dot, r_sh_en;
    logic          w_latch, w_lit;

    logic [NUM_DIGITS-1:0][3:0] w_data;
    logic [3:0]                 w_nib;
    logic                       w_dot_req;
    logic [6:0]                 w_seg_hi;
    logic [NUM_DIGITS-1:0]      w_onehot;
    logic [NUM_DIGITS-1:0]      w_sel_nxt;
    logic [6:0]                 w_seg_nxt;
    logic                       w_dot_nxt;

    logic [NUM_DIGITS-1:0] r_sel;
    logic [6:0]            r_seg;
    logic                  r_dot;

    assign w_data = i_digit_data;

    // On the latch edge the outputs load straight from the live inputs, since
    // the shadow registers only become valid on that same edge.
    assign w_nib     = (r_state == S_SHOW) ? r_sh_nib : w_data[r_idx];
    assign w_dot_req = (r_state == S_SHOW) ? r_sh_dot : i_dot_in[r_idx];

    hex_to_7seg u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg_hi)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_latch     = 1'b0;
        w_lit       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (i_enable) w_state_nxt = S_BLANK;
            end
            S_BLANK: begin
                if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_latch     = 1'b1;
                    w_lit       = i_digit_enable[r_idx];
                    w_state_nxt = S_SHOW;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_SHOW: begin
                if (r_cnt == CW'(SCAN_DIV - 1)) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
                    w_state_nxt = S_BLANK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_lit     = r_sh_en;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_latch     = 1'b0;
            w_lit       = 1'b0;
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
        w_sel_nxt = SEL_OFF;
        w_seg_nxt = SEG_OFF;
        w_dot_nxt = DOT_OFF;
        if (w_lit) begin
            w_sel_nxt = (SEL_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
            w_seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
            w_dot_nxt = w_dot_req ^ DOT_OFF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_BLANK;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_sh_nib <= '0;
            r_sh_dot <= 1'b0;
            r_sh_en  <= 1'b0;
            r_sel    <= SEL_OFF;
            r_seg    <= SEG_OFF;
            r_dot    <= DOT_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            if (w_latch) begin
                r_sh_nib <= w_data[r_idx];
                r_sh_dot <= i_dot_in[r_idx];
                r_sh_en  <= i_digit_enable[r_idx];
            end
            r_sel <= w_sel_nxt;
            r_seg <= w_seg_nxt;
            r_dot <= w_dot_nxt;
        end
    end

    assign o_digit_sel = r_sel;
    assign o_segments  = r_seg;
    assign o_dot       = r_dot;
    assign o_scan_idx  = r_idx;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (4 digits, SHOW=4, BLANK=1, active-low).
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] data = 16'h1234;
    logic [3:0]  den = 4'b1111;
    logic [3:0]  dotin = 4'b0000;
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        dot;
    logic [1:0]  idx;

    int total = 0;
    int bad   = 0;

    // Hand-computed active-low patterns for data 16'h1234, digit0..digit3.
    localparam logic [3:0][6:0] SEG_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    display_scan_controller #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
        .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_digit_data   (data),
        .i_digit_enable (den),
        .i_dot_in       (dotin),
        .o_digit_sel    (sel),
        .o_segments     (seg),
        .o_dot          (dot),
        .o_scan_idx     (idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Expected {sel,seg,dot,idx} at cycle k (k=1 is the first edge after reset release).
    function automatic logic [13:0] model(int k, logic [3:0] en, logic [3:0] dt,
                                          logic [3:0][6:0] segs);
        int p, d;
        logic [3:0] s;
        p = (k - 1) % 5;
        d = ((k - 1) / 5) % 4;
        if (p < 4 && en[d]) begin
            s = 4'b0001 << d;
            return {~s, segs[d], ~dt[d], 2'(d)};
        end
        if (p < 4) return {4'b1111, 7'h7F, 1'b1, 2'(d)};
        return {4'b1111, 7'h7F, 1'b1, 2'((d + 1) % 4)};
    endfunction

    task automatic test_reset();
        data = 16'h1234; den = 4'b1111; dotin = 4'b0000; enable = 1'b1;
        rst_n = 1'b0;
        step();
        total++;
        if ({sel, seg, dot, idx} !== {4'b1111, 7'h7F, 1'b1, 2'd0}) begin
            bad++; $display("FAIL reset_idle got=%h want=%h", {sel, seg, dot, idx}, {4'b1111, 7'h7F, 1'b1, 2'd0});
        end
        rst_n = 1'b1;
        step();
        total++;
        if ({sel, seg} !== {4'b1110, 7'b0011001}) begin
            bad++; $display("FAIL reset_first_lit got=%h want=%h", {sel, seg}, {4'b1110, 7'b0011001});
        end
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({sel, seg, dot, idx} !== {4'b1111, 7'h7F, 1'b1, 2'd0}) begin
            bad++; $display("FAIL reset_mid_show got=%h want=%h", {sel, seg, dot, idx}, {4'b1111, 7'h7F, 1'b1, 2'd0});
        end
        step();
        rst_n = 1'b1;
        step();
        total++;
        if ({sel, idx} !== {4'b1110, 2'd0}) begin
            bad++; $display("FAIL reset_release got=%h want=%h", {sel, idx}, {4'b1110, 2'd0});
        end
    endtask

    task automatic test_scan();
        logic [13:0] e;
        data = 16'h1234; den = 4'b1111; dotin = 4'b0000;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            step();
            e = model(k, den, dotin, SEG_1234);
            total++;
            if ({sel, seg, dot, idx} !== e) begin
                bad++; $display("FAIL scan k=%0d got=%h want=%h", k, {sel, seg, dot, idx}, e);
            end
        end
    endtask

    task automatic test_blank_dot();
        logic [13:0] e;
        data = 16'h1234; den = 4'b1011; dotin = 4'b0001;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step();
            e = model(k, den, dotin, SEG_1234);
            total++;
            if ({sel, seg, dot, idx} !== e) begin
                bad++; $display("FAIL blank_dot k=%0d got=%h want=%h", k, {sel, seg, dot, idx}, e);
            end
        end
        den = 4'b1111; dotin = 4'b0000;
    endtask

    task automatic test_no_glitch();
        data = 16'h1234; den = 4'b1111; dotin = 4'b0000;
        do_reset();
        for (int k = 1; k <= 6; k++) step();
        data = 16'hABCD;
        for (int k = 7; k <= 9; k++) begin
            step();
            total++;
            if ({sel, seg} !== {4'b1101, 7'b0110000}) begin
                bad++; $display("FAIL hold k=%0d got=%h want=%h", k, {sel, seg}, {4'b1101, 7'b0110000});
            end
        end
        step();
        step();
        total++;
        if ({sel, seg} !== {4'b1011, 7'b0000011}) begin
            bad++; $display("FAIL new_data got=%h want=%h", {sel, seg}, {4'b1011, 7'b0000011});
        end
        data = 16'h1234;
    endtask

    task automatic test_enable();
        data = 16'h1234; den = 4'b1111; dotin = 4'b0001;
        do_reset();
        for (int k = 1; k <= 12; k++) step();
        total++;
        if ({sel, idx} !== {4'b1011, 2'd2}) begin
            bad++; $display("FAIL pre_disable got=%h want=%h", {sel, idx}, {4'b1011, 2'd2});
        end
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if ({sel, seg, dot, idx} !== {4'b1111, 7'h7F, 1'b1, 2'd0}) begin
                bad++; $display("FAIL disabled c=%0d got=%h want=%h", k, {sel, seg, dot, idx}, {4'b1111, 7'h7F, 1'b1, 2'd0});
            end
        end
        enable = 1'b1;
        step();
        total++;
        if ({sel, seg, dot, idx} !== {4'b1111, 7'h7F, 1'b1, 2'd0}) begin
            bad++; $display("FAIL reenable_blank got=%h want=%h", {sel, seg, dot, idx}, {4'b1111, 7'h7F, 1'b1, 2'd0});
        end
        step();
        total++;
        if ({sel, seg, dot, idx} !== {4'b1110, 7'b0011001, 1'b0, 2'd0}) begin
            bad++; $display("FAIL reenable_lit got=%h want=%h", {sel, seg, dot, idx}, {4'b1110, 7'b0011001, 1'b0, 2'd0});
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_dot();
        test_no_glitch();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
